leb128_decoder: RTL and testbench

//  Byte-serial LEB128 immediate decoder between the ROM byte fetch and the cpu execute stage.

---
 rtl/leb128_decoder_pkg.sv | 16 +
 rtl/leb128_last_check.sv | 29 ++
 rtl/leb128_decoder.sv | 127 ++++++++++++
 tb/tb_leb128_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/leb128_decoder_pkg.sv
// Shared definitions for the byte-serial LEB128 immediate decoder.
//   leb_state_e   : decoder FSM states
//   LEB_MAX32/64  : maximum encoded length in bytes for i32 / i64 immediates
package leb128_decoder_pkg;

  typedef enum logic [1:0] {
    LEB_IDLE  = 2'd0,
    LEB_SHIFT = 2'd1,
    LEB_DONE  = 2'd2,
    LEB_ERROR = 2'd3
  } leb_state_e;

  localparam int LEB_MAX32 = 5;
  localparam int LEB_MAX64 = 10;

endpackage

// File: rtl/leb128_last_check.sv
// Legality of the byte that sits at the maximum encoded length (5th byte for
// i32, 10th byte for i64). Purely combinational so other decode paths
// (block types, memargs) can reuse the same rules.
//   byte_in   : candidate byte (bit7 = continuation)
//   is_signed : 1 = sLEB128
//   is64      : 1 = 64-bit immediate
//   legal     : 1 when the byte is an acceptable final byte at that position
module leb128_last_check (
  input  logic [7:0] byte_in,
  input  logic       is_signed,
  input  logic       is64,
  output logic       legal
);

  // Bits beyond the target width must be zero (unsigned) or copies of the
  // sign bit (signed); continuation at the last position is never legal.
  always_comb begin
    legal = 1'b0;
    if (!byte_in[7]) begin
      if (is64)
        legal = is_signed ? (byte_in[6:0] == 7'h00 || byte_in[6:0] == 7'h7F)
                          : (byte_in[6:1] == 6'h00);
      else
        legal = is_signed ? (byte_in[6:3] == 4'h0 || byte_in[6:3] == 4'hF)
                          : (byte_in[6:4] == 3'h0);
    end
  end

endmodule

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 immediate decoder (u32/s32/u64/s64), one byte per cycle
// on a valid/ready handshake.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a decode (honoured outside SHIFT only)
//   is_signed, is64       : mode, latched on start
//   byte_in/byte_valid    : stream byte and its valid
//   byte_ready            : high only while collecting bytes
//   value                 : decoded value, zero on malformed input
//   len                   : bytes consumed
//   done                  : one-cycle pulse when value/len are final
//   error                 : sticky malformed flag, cleared by start
module leb128_decoder
  import leb128_decoder_pkg::*;
#(
  parameter int MAX_BYTES = LEB_MAX64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is64,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [63:0] value,
  output logic [3:0]  len,
  output logic        done,
  output logic        error
);

  leb_state_e  state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  len_q, len_d;
  logic        err_q, err_d;
  logic        sgn_q, sgn_d;
  logic        w64_q, w64_d;

  logic        last_ok;
  logic        at_last;
  logic [3:0]  lim;
  logic [6:0]  sh_cur, sh_nxt, width;
  logic [70:0] lane_wide;
  logic [63:0] lane, fill, wmask;

  leb128_last_check u_last (
    .byte_in   (byte_in),
    .is_signed (sgn_q),
    .is64      (w64_q),
    .legal     (last_ok)
  );

  always_comb begin
    lim       = w64_q ? 4'(MAX_BYTES) : 4'(LEB_MAX32);
    at_last   = (len_q == lim - 4'd1);
    width     = w64_q ? 7'd64 : 7'd32;
    sh_cur    = 7'(len_q) * 7'd7;
    sh_nxt    = sh_cur + 7'd7;
    // Payload lands at bit 7*i; anything shifted past bit 63 is dropped.
    lane_wide = 71'(byte_in[6:0]) << sh_cur;
    lane      = lane_wide[63:0];
    // Sign fill above the payload only when it ends below the target width.
    fill      = (sgn_q && byte_in[6] && sh_nxt < width) ? ~((64'd1 << sh_nxt) - 64'd1) : '0;
    wmask     = w64_q ? '1 : 64'h0000_0000_FFFF_FFFF;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    err_d   = err_q;
    sgn_d   = sgn_q;
    w64_d   = w64_q;
    case (state_q)
      LEB_SHIFT: begin
        if (byte_valid) begin
          len_d = len_q + 4'd1;
          acc_d = acc_q | lane;
          if (at_last && !last_ok) begin
            state_d = LEB_ERROR;
            acc_d   = '0;
            err_d   = 1'b1;
          end else if (!byte_in[7]) begin
            state_d = LEB_DONE;
            acc_d   = (acc_q | lane | fill) & wmask;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = LEB_SHIFT;
          acc_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
          sgn_d   = is_signed;
          w64_d   = is64;
        end else begin
          state_d = LEB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LEB_IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      sgn_q   <= 1'b0;
      w64_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      sgn_q   <= sgn_d;
      w64_q   <= w64_d;
    end
  end

  assign byte_ready = (state_q == LEB_SHIFT);
  assign done       = (state_q == LEB_DONE);
  assign value      = acc_q;
  assign len        = len_q;
  assign error      = err_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Randomized + directed bench for leb128_decoder. The reference model decodes
// the byte list as an integer and judges legality by numeric range.
module tb_leb128_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_signed, is64;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [63:0] value;
  logic [3:0]  len;
  logic        done, error;

  leb128_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .is64       (is64),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .value      (value),
    .len        (len),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] bq[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Decode bq as a plain integer, apply two's complement for signed, then
  // reject anything that does not fit the target width.
  function automatic void model(input bit sgn, input bit w64,
                                output logic [63:0] val, output int n, output bit err);
    logic signed [127:0] v, lo, hi;
    int lim, width;
    lim   = w64 ? 10 : 5;
    width = w64 ? 64 : 32;
    v = '0; err = 1'b0; n = 0; val = '0;
    for (int k = 0; k < bq.size(); k++) begin
      n = k + 1;
      v = v + (128'(bq[k][6:0]) << (7 * k));
      if (!bq[k][7]) begin
        if (sgn && bq[k][6]) v = v - (128'sd1 <<< (7 * (k + 1)));
        if (sgn) begin
          hi = 128'sd1 <<< (width - 1);
          lo = -hi;
        end else begin
          hi = 128'sd1 <<< width;
          lo = 128'sd0;
        end
        err = !(v >= lo && v < hi);
        break;
      end else if (k == lim - 1) begin
        err = 1'b1;
        break;
      end
    end
    if (!err) val = w64 ? v[63:0] : {32'h0, v[31:0]};
  endfunction

  task automatic gen(input bit sgn, input bit w64);
    longint          x;
    longint unsigned u;
    logic [7:0]      b;
    bit              fin;
    int              lim, n;
    lim = w64 ? 10 : 5;
    bq.delete();
    if ($urandom_range(0, 1) == 1) begin
      u = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (sgn) begin
        x = w64 ? longint'(u) : longint'(int'(u[31:0]));
        if ($urandom_range(0, 1) == 1) x = -x;
        do begin
          b = {1'b0, x[6:0]};
          x = x >>> 7;
          fin = (x == 0 && !b[6]) || (x == -1 && b[6]);
          if (!fin) b[7] = 1'b1;
          bq.push_back(b);
        end while (!fin);
      end else begin
        if (!w64) u = u & 64'hFFFF_FFFF;
        do begin
          b = {1'b0, u[6:0]};
          u = u >> 7;
          if (u != 0) b[7] = 1'b1;
          bq.push_back(b);
        end while (u != 0);
      end
    end else begin
      n = $urandom_range(1, lim);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        b[7] = (k < n - 1);
        if (k == lim - 1 && $urandom_range(0, 3) == 0) b[7] = 1'b1;
        bq.push_back(b);
      end
    end
  endtask

  // Entered on a negedge; returns on the negedge where done/error is visible.
  task automatic decode(input bit sgn, input bit w64, input bit stall, input string tag);
    logic [63:0] ev;
    int          elen, k;
    bit          eerr;
    model(sgn, w64, ev, elen, eerr);
    start = 1'b1; is_signed = sgn; is64 = w64; byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " ready_after_start"}, 64'(byte_ready), 64'd1);
    chk({tag, " err_cleared"}, 64'(error), 64'd0);
    chk({tag, " len_cleared"}, 64'(len), 64'd0);
    k = 0;
    while (k < bq.size()) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        start      = 1'($urandom_range(0, 1));
        is_signed  = 1'($urandom_range(0, 1));
        is64       = 1'($urandom_range(0, 1));
      end else begin
        byte_valid = 1'b1;
        byte_in    = bq[k];
        start      = 1'b0;
        k++;
      end
      chk({tag, " ready"}, 64'(byte_ready), 64'd1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    chk({tag, " done"}, 64'(done), 64'(!eerr));
    chk({tag, " error"}, 64'(error), 64'(eerr));
    chk({tag, " value"}, value, ev);
    chk({tag, " ready_low"}, 64'(byte_ready), 64'd0);
    if (!eerr) chk({tag, " len"}, 64'(len), 64'(elen));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sgn, w64, stall, was_err;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; is64 = 1'b0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst value", value, 64'd0);
    chk("rst len", 64'(len), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    chk("rst ready", 64'(byte_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    bq = '{8'hE5, 8'h8E, 8'h26}; decode(0, 0, 0, "u32_98765");
    chk("u32_98765 const", value, 64'h0000_0000_0009_8765);
    // back-to-back: start issued in the DONE cycle
    bq = '{8'hC0, 8'hBB, 8'h78}; decode(1, 0, 0, "s32_neg");
    chk("s32_neg const", value, 64'h0000_0000_FFFE_1DC0);
    bq = '{8'h7F}; decode(1, 1, 0, "s64_m1");
    chk("s64_m1 const", value, 64'hFFFF_FFFF_FFFF_FFFF);
    bq.delete();
    for (int k = 0; k < 9; k++) bq.push_back(8'hFF);
    bq.push_back(8'h01);
    decode(0, 1, 0, "u64_max");
    chk("u64_max len", 64'(len), 64'd10);
    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80}; decode(0, 0, 0, "u32_cont5");
    @(negedge clk);
    chk("sticky error", 64'(error), 64'd1);
    chk("no done idle", 64'(done), 64'd0);
    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h10}; decode(0, 0, 0, "u32_over");
    @(negedge clk);
    bq = '{8'hE5, 8'h8E, 8'h26}; decode(1, 0, 1, "s32_stall");
    chk("s32_stall const", value, 64'h0000_0000_0009_8765);
    @(negedge clk);

    // reset in the middle of a decode
    start = 1'b1; is_signed = 1'b0; is64 = 1'b0;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'hE5;
    @(negedge clk);
    byte_in = 8'h8E;
    @(negedge clk);
    byte_in = 8'h26; reset = 1'b1;
    @(negedge clk);
    chk("midrst ready", 64'(byte_ready), 64'd0);
    chk("midrst len", 64'(len), 64'd0);
    chk("midrst value", value, 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    reset = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    bq = '{8'h02}; decode(0, 0, 0, "post_rst");
    chk("post_rst const", value, 64'd2);

    for (int it = 0; it < 200; it++) begin
      sgn   = 1'($urandom_range(0, 1));
      w64   = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      gen(sgn, w64);
      decode(sgn, w64, stall, "rand");
      was_err = error;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rand idle done", 64'(done), 64'd0);
        chk("rand idle ready", 64'(byte_ready), 64'd0);
        chk("rand idle error", 64'(error), 64'(was_err));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
